delay_slot_scheduler: RTL and testbench

- Shares one programmable-depth delay pipeline among NCH channel requesters.
- Each channel raises a single-cycle request pulse; a round-robin arbiter grants at most one channel per cycle into the pipeline.
- The granted pulse re-emerges on that channel's out_pulse bit exactly cur_delay cycles later.
- A configuration sequencer drains the pipeline before applying a new delay, so no in-flight pulse is ever emitted with a mixed delay.

---
 rtl/delay_slot_scheduler.sv | 172 +++++++++++++++++
 tb/tb_delay_slot_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_slot_scheduler.sv
// Round-robin admission of NCH pulse requesters into one shared delay pipeline.
// Delay changes drain in-flight pulses at the old delay before the new one is applied.
module delay_slot_scheduler #(
   parameter int unsigned NCH           = 32,
   parameter int unsigned MAX_DELAY     = 16,
   parameter int unsigned DW            = 5,
   parameter int unsigned DEFAULT_DELAY = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] req,
   output logic [NCH-1:0] grant,
   output logic [NCH-1:0] out_pulse,
   output logic [NCH-1:0] drop,
   input  logic           drop_clr,
   input  logic [DW-1:0]  cfg_delay,
   input  logic           cfg_load,
   output logic           cfg_busy,
   output logic           cfg_err,
   output logic [DW-1:0]  cur_delay
);

   localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned SW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

   typedef enum logic [1:0] {StRun, StDrain, StApply} state_e;

   state_e               state_q, state_d;
   logic [NCH-1:0]       pending_q, pending_d;
   logic [NCH-1:0]       drop_q, drop_d;
   logic [NCH-1:0]       grant_q, grant_d;
   logic [NCH-1:0]       out_q, out_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [IW-1:0]        win;
   logic                 found;
   logic [MAX_DELAY-1:0] valid_q;
   logic [IW-1:0]        id_q [MAX_DELAY];
   logic [DW-1:0]        cur_q, new_q;
   logic                 cfg_err_q, cfg_err_d;
   logic                 cfg_ok, accept, inflight, pipe_clr, arb_en;
   logic [DW-1:0]        tap_full;
   logic [SW-1:0]        tap;

   // First pending channel at or above the pointer, wrapping at NCH-1.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NCH; k++) begin
         if (!found && pending_q[(int'(ptr_q) + k) % NCH]) begin
            found = 1'b1;
            win   = IW'((int'(ptr_q) + k) % NCH);
         end
      end
   end

   always_comb begin
      grant_d = '0;
      ptr_d   = ptr_q;
      if (arb_en && found) begin
         grant_d[win] = 1'b1;
         ptr_d        = (win == IW'(NCH - 1)) ? '0 : win + IW'(1);
      end
   end

   // A request landing on an already-pending, ungranted channel is lost.
   always_comb begin
      pending_d = (pending_q & ~grant_d) | req;
      drop_d    = (drop_q & ~{NCH{drop_clr}}) | (req & pending_q & ~grant_d);
   end

   always_comb begin
      tap_full = cur_q - DW'(1);
      tap      = tap_full[SW-1:0];
      out_d    = '0;
      if (valid_q[tap]) begin
         out_d[id_q[tap]] = 1'b1;
      end
   end

   // Only stages that can still reach the output tap count as in flight.
   always_comb begin
      inflight = 1'b0;
      for (int unsigned s = 0; s < MAX_DELAY; s++) begin
         if (valid_q[s] && (s < 32'(cur_q))) begin
            inflight = 1'b1;
         end
      end
      cfg_ok = (cfg_delay != '0) && (32'(cfg_delay) <= MAX_DELAY);
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun: begin
            if (cfg_load && cfg_ok) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!inflight) begin
               state_d = StApply;
            end
         end
         StApply: state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   // FSM: outputs
   always_comb begin
      arb_en    = (state_q == StRun);
      cfg_busy  = (state_q != StRun);
      accept    = (state_q == StRun) && cfg_load && cfg_ok;
      cfg_err_d = (state_q == StRun) && cfg_load && !cfg_ok;
      pipe_clr  = (state_q == StApply);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         drop_q    <= '0;
         grant_q   <= '0;
         out_q     <= '0;
         ptr_q     <= '0;
         valid_q   <= '0;
         cur_q     <= DW'(DEFAULT_DELAY);
         new_q     <= DW'(DEFAULT_DELAY);
         cfg_err_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         drop_q    <= drop_d;
         grant_q   <= grant_d;
         out_q     <= out_d;
         ptr_q     <= ptr_d;
         cfg_err_q <= cfg_err_d;
         if (pipe_clr) begin
            valid_q <= '0;
            cur_q   <= new_q;
         end else begin
            valid_q <= {valid_q[MAX_DELAY-2:0], |grant_d};
         end
         if (accept) begin
            new_q <= cfg_delay;
         end
      end
   end

   // Channel ids need no reset; they are qualified by valid_q.
   always_ff @(posedge clk) begin
      id_q[0] <= win;
      for (int s = 1; s < MAX_DELAY; s++) begin
         id_q[s] <= id_q[s-1];
      end
   end

   assign grant     = grant_q;
   assign out_pulse = out_q;
   assign drop      = drop_q;
   assign cfg_err   = cfg_err_q;
   assign cur_delay = cur_q;

endmodule

// File: tb/tb_delay_slot_scheduler.sv
// Directed bench for delay_slot_scheduler: arbitration, delay timing, drops,
// reconfiguration drain, rejected loads and reset flush.
module tb_delay_slot_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] req;
   logic [31:0] grant, out_pulse, drop;
   logic        drop_clr;
   logic [4:0]  cfg_delay;
   logic        cfg_load;
   logic        cfg_busy, cfg_err;
   logic [4:0]  cur_delay;

   int n_vec = 0;
   int n_err = 0;

   delay_slot_scheduler #(
      .NCH           (32),
      .MAX_DELAY     (16),
      .DW            (5),
      .DEFAULT_DELAY (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .grant     (grant),
      .out_pulse (out_pulse),
      .drop      (drop),
      .drop_clr  (drop_clr),
      .cfg_delay (cfg_delay),
      .cfg_load  (cfg_load),
      .cfg_busy  (cfg_busy),
      .cfg_err   (cfg_err),
      .cur_delay (cur_delay)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req       = '0;
      drop_clr  = 1'b0;
      cfg_load  = 1'b0;
      cfg_delay = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      do_reset();
      check_eq("rst_grant", grant, 0);
      check_eq("rst_out", out_pulse, 0);
      check_eq("rst_drop", drop, 0);
      check_eq("rst_busy", cfg_busy, 0);
      check_eq("rst_err", cfg_err, 0);
      check_eq("rst_cur", cur_delay, 2);

      // Single request on channel 5
      req = 32'h20;
      tick();
      req = '0;
      check_eq("s1_no_grant_yet", grant, 0);
      tick();
      check_eq("s1_grant5", grant, 32'h20);
      tick();
      check_eq("s1_grant_off", grant, 0);
      check_eq("s1_out_early", out_pulse, 0);
      tick();
      check_eq("s1_out5", out_pulse, 32'h20);
      tick();
      check_eq("s1_out_off", out_pulse, 0);
      check_eq("s1_drop", drop, 0);

      // Three simultaneous requests from pointer 0
      do_reset();
      req = 32'h7;
      tick();
      req = '0;
      tick();
      check_eq("s2_g0", grant, 32'h1);
      tick();
      check_eq("s2_g1", grant, 32'h2);
      tick();
      check_eq("s2_g2", grant, 32'h4);
      check_eq("s2_o0", out_pulse, 32'h1);
      tick();
      check_eq("s2_gnone", grant, 0);
      check_eq("s2_o1", out_pulse, 32'h2);
      tick();
      check_eq("s2_o2", out_pulse, 32'h4);
      tick();
      check_eq("s2_ooff", out_pulse, 0);
      // Pointer should now be 3: channel 3 beats channel 0
      req = 32'h9;
      tick();
      req = '0;
      tick();
      check_eq("s2_ptr3_first", grant, 32'h8);
      tick();
      check_eq("s2_ptr_wrap", grant, 32'h1);
      tick();
      tick();
      tick();

      // Drop on channel 3 while channel 0 is granted; set wins over drop_clr
      do_reset();
      req = 32'h9;
      tick();
      req      = 32'h8;
      drop_clr = 1'b1;
      tick();
      req      = '0;
      drop_clr = 1'b0;
      check_eq("s3_grant0", grant, 32'h1);
      check_eq("s3_drop3", drop, 32'h8);
      tick();
      check_eq("s3_grant3", grant, 32'h8);
      tick();
      check_eq("s3_out0", out_pulse, 32'h1);
      tick();
      check_eq("s3_out3", out_pulse, 32'h8);
      tick();
      check_eq("s3_out_once_a", out_pulse, 0);
      tick();
      check_eq("s3_out_once_b", out_pulse, 0);
      drop_clr = 1'b1;
      tick();
      drop_clr = 1'b0;
      check_eq("s3_drop_clr", drop, 0);

      // Stream on channel 7, then reconfigure to delay 9
      do_reset();
      req = 32'h80;
      tick();
      tick();
      check_eq("s4_g_a", grant, 32'h80);
      tick();
      check_eq("s4_g_b", grant, 32'h80);
      tick();
      check_eq("s4_o_a", out_pulse, 32'h80);
      req       = '0;
      cfg_delay = 5'd9;
      cfg_load  = 1'b1;
      tick();
      cfg_load = 1'b0;
      check_eq("s4_last_grant", grant, 32'h80);
      check_eq("s4_busy_on", cfg_busy, 1);
      check_eq("s4_o_b", out_pulse, 32'h80);
      tick();
      check_eq("s4_no_grant_drain", grant, 0);
      check_eq("s4_o_c", out_pulse, 32'h80);
      cfg_delay = 5'd0;
      cfg_load  = 1'b1;
      tick();
      cfg_load = 1'b0;
      check_eq("s4_o_last", out_pulse, 32'h80);
      check_eq("s4_err_ignored", cfg_err, 0);
      check_eq("s4_busy_drain", cfg_busy, 1);
      tick();
      check_eq("s4_out_apply", out_pulse, 0);
      check_eq("s4_busy_apply", cfg_busy, 1);
      tick();
      check_eq("s4_busy_off", cfg_busy, 0);
      check_eq("s4_cur9", cur_delay, 9);
      check_eq("s4_out_run", out_pulse, 0);
      req = 32'h80;
      tick();
      req = '0;
      tick();
      check_eq("s4_grant_new", grant, 32'h80);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check_eq("s4_wait9", out_pulse, 0);
      end
      tick();
      check_eq("s4_out_d9", out_pulse, 32'h80);
      tick();
      check_eq("s4_out_d9_off", out_pulse, 0);

      // Rejected loads: 0 and 17
      do_reset();
      cfg_delay = 5'd0;
      cfg_load  = 1'b1;
      tick();
      cfg_load = 1'b0;
      check_eq("s5_err0", cfg_err, 1);
      check_eq("s5_busy0", cfg_busy, 0);
      tick();
      check_eq("s5_err0_off", cfg_err, 0);
      check_eq("s5_cur0", cur_delay, 2);
      cfg_delay = 5'd17;
      cfg_load  = 1'b1;
      tick();
      cfg_load = 1'b0;
      check_eq("s5_err17", cfg_err, 1);
      check_eq("s5_busy17", cfg_busy, 0);
      tick();
      check_eq("s5_err17_off", cfg_err, 0);
      check_eq("s5_cur17", cur_delay, 2);
      check_eq("s5_busy_end", cfg_busy, 0);

      // Reset with pulses in flight and pending full
      do_reset();
      req = 32'hFF;
      tick();
      tick();
      check_eq("s6_drop_pre", drop, 32'hFE);
      tick();
      req = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("s6_grant", grant, 0);
      check_eq("s6_out", out_pulse, 0);
      check_eq("s6_drop", drop, 0);
      check_eq("s6_busy", cfg_busy, 0);
      check_eq("s6_err", cfg_err, 0);
      check_eq("s6_cur", cur_delay, 2);
      for (int i = 0; i < 6; i++) begin
         tick();
         check_eq("s6_quiet", out_pulse | grant, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
